bcd_seq_converter: RTL

BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

---
 rtl/bcd_seq_converter_pkg.sv | 20 ++
 rtl/bcd_seq_converter_add3.sv | 14 +
 rtl/bcd_seq_converter.sv | 92 +++++++++
 3 files changed

// File: rtl/bcd_seq_converter_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Double dabble: add 3 to nibbles >= 5, then shift left.
package bcd_seq_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] ADD3_TH = 4'd5;

  function automatic logic [3:0] add3_fix(
    input logic [3:0] d
  );
    return (d >= ADD3_TH) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_seq_converter_add3.sv
// Combinational correction for one BCD nibble.
// Values of 5 or more get 3 added before the next doubling.
module add3
  import bcd_seq_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  always_comb begin
    q = add3_fix(d);
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter.
// FSM, bit counter and result registers; one add3 per nibble.
module bcd_seq_converter
  import bcd_seq_converter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds
);

  localparam int SW = DIGITS * DIGIT_W;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = SW + WIDTH;

  state_t           state;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    fixed;
  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    shifted;
  logic             accept;
  logic             last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    add3 u_add3 (
      .d (scratch[g*DIGIT_W +: DIGIT_W]),
      .q (fixed[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted = {fixed, operand} << 1;
  assign accept  = start && (state == IDLE || state == DONE);
  assign last    = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      scratch  <= '0;
      operand  <= '0;
      cnt      <= '0;
      ones     <= '0;
      tens     <= '0;
      hundreds <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            operand <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          scratch <= shifted[TW-1:WIDTH];
          operand <= shifted[WIDTH-1:0];
          cnt     <= cnt - CW'(1);
          // Digits come from the final shifted value, never mid-conversion.
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            ones     <= shifted[WIDTH +: 4];
            tens     <= shifted[WIDTH+4 +: 4];
            hundreds <= shifted[WIDTH+8 +: 4];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
